// File: rtl/log_energy_arbiter.sv
// log_energy_arbiter: one 6*floor(log2(x)) converter shared by NUM_REQ energy producers (rev 1.0).
// Build option: define LOG_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
`default_nettype none

module log_energy_log2 (
  input  logic [31:0] operand,
  output logic [7:0]  log_val
);
  logic [4:0] msb;

  always_comb begin
    msb = '0;
    for (int i = 0; i < 32; i++) begin
      if (operand[i]) msb = 5'(i);
    end
  end

  // 6*31 = 186 fits in 8 bits, so no saturation is needed.
  assign log_val = {3'b000, msb} * 8'd6;
endmodule

module log_energy_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  input  logic [NUM_REQ*32-1:0] req_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [7:0]           out_log_o,
  output logic [ID_W-1:0]      out_id_o,
  output logic                 out_zero_o,
  output logic                 busy_o
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [ID_W-1:0] grant_id;
  logic            grant_any;
  logic            accept_slot;
  logic            take;
  logic [31:0]     sel_data;
  logic [31:0]     operand;
  logic [7:0]      conv_log;

`ifdef LOG_ARB_FIXED_PRIO_EN
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      automatic logic [ID_W-1:0] ci = ID_W'(i);
      if (req_valid_i[ci]) begin
        grant_any = 1'b1;
        grant_id  = ci;
      end
    end
  end
`else
  logic [ID_W-1:0] rr_ptr;

  // Search begins at the pointer and wraps, so a lone requester always wins.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      automatic logic [ID_W-1:0] idx = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!grant_any && req_valid_i[idx]) begin
        grant_any = 1'b1;
        grant_id  = idx;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
    end else if (take) begin
      rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
    end
  end
`endif

  // A new grant can ride on the same edge as the output handshake.
  assign accept_slot = (state == ST_IDLE) || ((state == ST_OUT) && out_ready_i);
  assign take        = accept_slot && grant_any && !rst_i;

  always_comb begin
    sel_data = req_data_i[32*int'(grant_id) +: 32];
  end

  log_energy_log2 u_log2 (
    .operand (operand),
    .log_val (conv_log)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (take) state_nxt = ST_CONV;
      ST_CONV: state_nxt = ST_OUT;
      ST_OUT:  if (out_ready_i) state_nxt = take ? ST_CONV : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    out_valid_o = (state == ST_OUT);
    busy_o      = (state != ST_IDLE);
    req_ready_o = '0;
    if (take) req_ready_o[grant_id] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      operand    <= '0;
      out_id_o   <= '0;
      out_log_o  <= '0;
      out_zero_o <= 1'b0;
    end else begin
      if (take) begin
        operand  <= sel_data;
        out_id_o <= grant_id;
      end
      if (state == ST_CONV) begin
        out_log_o  <= conv_log;
        out_zero_o <= (operand == 32'd0);
      end
    end
  end
endmodule

`default_nettype wire
